sync_fifo_prog: RTL

//  Parametrised single-clock FIFO, successor to the fixed 256x32 sync FIFO cores.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sdp_ram_1clk.sv | 76 +++++++
 rtl/sync_fifo_prog.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable synchronous FIFO:
//   - read-mode constants (standard / first-word-fall-through)
//   - level_width(): width of pointers and the water level (one extra MSB
//     that tells full apart from empty after wrap-around)
//   - reset values of the status flags, used for both reset and flush
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam bit FIFO_STD  = 1'b0;
    localparam bit FIFO_FWFT = 1'b1;

    localparam logic RST_RD_EMPTY     = 1'b1;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_WR_FULL      = 1'b0;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_OVERFLOW     = 1'b0;
    localparam logic RST_UNDERFLOW    = 1'b0;

    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// ---------------------------------------------------------------------------
// sdp_ram_1clk
// Simple dual-port RAM, one clock, synchronous read with an optional second
// output register. The read data register only updates when rd_en is high,
// so the last word read is held at the output.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset of the read data registers
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_en    in   read strobe (loads the read data register)
//   rd_addr  in   read address
//   rd_data  out  read word, 1 clk after rd_en (2 clk with OUT_REG)
// ---------------------------------------------------------------------------
module sdp_ram_1clk #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q_reg;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q_reg <= '0;
        end else if (rd_en) begin
            ram_q_reg <= mem[rd_addr];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic                  rd_en_d_reg;
            logic [DATA_WIDTH-1:0] dout_reg;

            // Second stage follows the first only for words actually read,
            // so the output still holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_en_d_reg <= 1'b0;
                    dout_reg    <= '0;
                end else begin
                    rd_en_d_reg <= rd_en;
                    if (rd_en_d_reg) begin
                        dout_reg <= ram_q_reg;
                    end
                end
            end

            assign rd_data = dout_reg;
        end else begin : g_no_out_reg
            assign rd_data = ram_q_reg;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read mode, runtime almost-full/almost-empty thresholds, synchronous flush
// and sticky overflow/underflow flags.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   flush         in   synchronous clear of contents (wins over wr_en/rd_en)
//   wr_en         in   write request
//   wr_data       in   write word
//   wr_full       out  no space; writes ignored
//   rd_en         in   read request (FWFT: pop the head word)
//   rd_data       out  read word
//   rd_empty      out  no readable word
//   af_thresh     in   almost_full when level >= af_thresh
//   ae_thresh     in   almost_empty when level <= ae_thresh
//   almost_full   out  registered threshold flag
//   almost_empty  out  registered threshold flag
//   water_level   out  words held, including the FWFT output stage
//   overflow      out  sticky: wr_en while wr_full
//   underflow     out  sticky: rd_en while rd_empty
//   clr_err       in   clears overflow/underflow (wins over a new event)
// ---------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int FWFT        = 0,
    parameter int RAM_OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int            LW       = level_width(ADDR_WIDTH);
    localparam bit            MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    // The extra output register only applies to standard mode.
    localparam bit            USE_OREG = (MODE == FIFO_STD) && (RAM_OUT_REG != 0);
    localparam logic [LW-1:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [LW-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [LW-1:0] rd_ptr_reg,     rd_ptr_next;
    logic [LW-1:0] fetch_ptr_reg,  fetch_ptr_next;
    logic [LW-1:0] level_reg,      level_next;
    logic          dout_valid_reg, dout_valid_next;
    logic          wr_full_reg,    wr_full_next;
    logic          rd_empty_reg,   rd_empty_next;
    logic          almost_full_reg,  almost_full_next;
    logic          almost_empty_reg, almost_empty_next;
    logic          overflow_reg,   overflow_next;
    logic          underflow_reg,  underflow_next;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  fetch;
    logic                  ram_wr_en;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;

    // rd_ptr counts words handed to the user; in FWFT mode fetch_ptr runs
    // ahead of it by the word sitting in the RAM output register, which is
    // why the level (wr_ptr - rd_ptr) includes that output stage.
    always_comb begin
        wr_accept = wr_en & ~wr_full_reg;
        rd_accept = rd_en & ~rd_empty_reg;

        // Refill the output stage when it is empty or being popped this
        // cycle; the latter keeps back-to-back pops at one word per clock.
        fetch = 1'b0;
        if (MODE == FIFO_FWFT) begin
            fetch = (fetch_ptr_reg != wr_ptr_reg) & (~dout_valid_reg | rd_accept);
        end

        wr_ptr_next     = wr_ptr_reg + LW'(wr_accept);
        rd_ptr_next     = rd_ptr_reg + LW'(rd_accept);
        fetch_ptr_next  = fetch_ptr_reg + LW'(fetch);
        dout_valid_next = fetch | (dout_valid_reg & ~rd_accept);

        if (flush) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            fetch_ptr_next  = '0;
            dout_valid_next = 1'b0;
        end

        level_next        = wr_ptr_next - rd_ptr_next;
        wr_full_next      = (level_next == DEPTH);
        rd_empty_next     = (MODE == FIFO_FWFT) ? ~dout_valid_next : (level_next == '0);
        almost_full_next  = (level_next >= af_thresh);
        almost_empty_next = (level_next <= ae_thresh);

        overflow_next  = clr_err ? 1'b0 : (overflow_reg  | (wr_en & wr_full_reg));
        underflow_next = clr_err ? 1'b0 : (underflow_reg | (rd_en & rd_empty_reg));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fetch_ptr_reg    <= '0;
            level_reg        <= '0;
            dout_valid_reg   <= 1'b0;
            wr_full_reg      <= RST_WR_FULL;
            rd_empty_reg     <= RST_RD_EMPTY;
            almost_full_reg  <= RST_ALMOST_FULL;
            almost_empty_reg <= RST_ALMOST_EMPTY;
            overflow_reg     <= RST_OVERFLOW;
            underflow_reg    <= RST_UNDERFLOW;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            fetch_ptr_reg    <= fetch_ptr_next;
            level_reg        <= level_next;
            dout_valid_reg   <= dout_valid_next;
            wr_full_reg      <= wr_full_next;
            rd_empty_reg     <= rd_empty_next;
            almost_full_reg  <= almost_full_next;
            almost_empty_reg <= almost_empty_next;
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    // A flush cycle issues no RAM read so rd_data keeps its last value.
    assign ram_wr_en   = wr_accept & ~flush;
    assign ram_rd_en   = ~flush & ((MODE == FIFO_FWFT) ? fetch : rd_accept);
    assign ram_rd_addr = (MODE == FIFO_FWFT) ? fetch_ptr_reg[ADDR_WIDTH-1:0]
                                             : rd_ptr_reg[ADDR_WIDTH-1:0];

    sdp_ram_1clk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUT_REG    (USE_OREG)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );

    assign wr_full      = wr_full_reg;
    assign rd_empty     = rd_empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign water_level  = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
